// File: rtl/cover_pkg.sv
// rtl/cover_pkg.sv - shared types and constants for toggle-cover collectors
package cover_pkg;

    localparam int COVER_IDX_W         = 64;
    localparam int COVER_TOTAL_DEFAULT = 8744;

    typedef logic [COVER_IDX_W-1:0] cover_index_t;

    // Index width for an n-entry vector, never narrower than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cover_prio_enc.sv
// rtl/cover_prio_enc.sv - lowest-set-bit priority encoder
module cover_prio_enc
    import cover_pkg::*;
#(
    parameter  int WIDTH = 130,
    localparam int IDX_W = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    output logic             any,
    output logic [IDX_W-1:0] idx,
    output logic [WIDTH-1:0] onehot
);

    assign any = |req;

    // Two's-complement trick isolates the lowest set bit
    assign onehot = req & (~req + WIDTH'(1));

    // Scan high to low so the lowest set bit is the last one written
    always_comb begin
        idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/toggle_cover_collector.sv
// rtl/toggle_cover_collector.sv - sticky toggle-cover bitmap with first-hit index stream
module toggle_cover_collector
    import cover_pkg::*;
#(
    parameter  int WIDTH       = 130,
    parameter  int COVER_INDEX = 0,
    parameter  int COVER_TOTAL = COVER_TOTAL_DEFAULT,
    localparam int CNT_W       = $clog2(WIDTH + 1),
    localparam int IDX_W       = idx_width(WIDTH)
) (
    input  logic                   gbl_clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   clear,
    input  logic [WIDTH-1:0]       valid,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [COVER_IDX_W-1:0] out_index,
    output logic [WIDTH-1:0]       covered,
    output logic [CNT_W-1:0]       reported_cnt,
    output logic                   all_covered
);

    // This group must fit inside the design-wide index space
    generate
        if (COVER_INDEX + WIDTH > COVER_TOTAL) begin : g_range_check
            $error("toggle_cover_collector: COVER_INDEX + WIDTH exceeds COVER_TOTAL");
        end
    endgenerate

    logic [WIDTH-1:0]   covered_q, covered_d;
    logic [WIDTH-1:0]   pending_q, pending_d;
    logic               out_valid_q, out_valid_d;
    cover_index_t       out_index_q, out_index_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [WIDTH-1:0]   hits;
    logic [WIDTH-1:0]   new_hits;
    logic               pend_any;
    logic [IDX_W-1:0]   pop_idx;
    logic [WIDTH-1:0]   pop_onehot;
    logic               stage_free;
    logic               pop;
    logic               xfer;

    // Lowest pending point goes out first
    cover_prio_enc #(
        .WIDTH (WIDTH)
    ) u_prio_enc (
        .req    (pending_q),
        .any    (pend_any),
        .idx    (pop_idx),
        .onehot (pop_onehot)
    );

    assign hits       = en ? valid : '0;
    assign new_hits   = hits & ~covered_q;
    assign stage_free = ~out_valid_q | out_ready;
    assign pop        = stage_free & pend_any;
    assign xfer       = out_valid_q & out_ready;

    // Next-state: capture first hits, load the output stage, count accepted beats
    always_comb begin
        covered_d   = covered_q | hits;
        pending_d   = (pending_q & ~(pop ? pop_onehot : '0)) | new_hits;
        out_valid_d = stage_free ? pend_any : out_valid_q;
        out_index_d = pop ? (cover_index_t'(COVER_INDEX) + cover_index_t'(pop_idx)) : out_index_q;
        cnt_d       = (xfer && (cnt_q != CNT_W'(WIDTH))) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // State update; reset beats clear, clear beats everything else in the cycle
    always_ff @(posedge gbl_clk) begin
        if (!reset) begin
            covered_q   <= '0;
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            cnt_q       <= '0;
        end else if (clear) begin
            covered_q   <= '0;
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            covered_q   <= covered_d;
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            out_index_q <= out_index_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_index    = out_index_q;
    assign covered      = covered_q;
    assign reported_cnt = cnt_q;
    assign all_covered  = (cnt_q == CNT_W'(WIDTH));

endmodule
